// File: rtl/cnn_layer_sched_pkg.sv
// Shared definitions for the CNN layer sequencer: default widths, FSM state
// encoding, error codes and the descriptor word layout used by the host driver.
package cnn_layer_sched_pkg;

    localparam int unsigned W_SIZE_DEF       = 10;
    localparam int unsigned W_CHANNEL_DEF    = 8;
    localparam int unsigned W_FRAME_SIZE_DEF = 16;
    localparam int unsigned N_LAYER_DEF      = 16;
    localparam int unsigned W_LAYER_DEF      = 4;
    localparam int unsigned W_TIMEOUT_DEF    = 24;
    localparam int unsigned W_DESC_DEF       = 2 * W_SIZE_DEF + 2 * W_CHANNEL_DEF;

    // Descriptor word: {channel_out, channel_in, height, width}, width in LSBs
    localparam int unsigned DescWidthLsb  = 0;
    localparam int unsigned DescHeightLsb = W_SIZE_DEF;
    localparam int unsigned DescChInLsb   = 2 * W_SIZE_DEF;
    localparam int unsigned DescChOutLsb  = 2 * W_SIZE_DEF + W_CHANNEL_DEF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StCalc  = 3'd2,
        StRst   = 3'd3,
        StStart = 3'd4,
        StRun   = 3'd5,
        StDone  = 3'd6
    } sched_state_e;

    typedef enum logic [1:0] {
        ErrNone    = 2'b00,
        ErrDesc    = 2'b01,
        ErrTimeout = 2'b10,
        ErrAbort   = 2'b11
    } sched_err_e;

    // Build a descriptor word in the default layout
    function automatic logic [W_DESC_DEF-1:0] pack_desc(
        input logic [W_SIZE_DEF-1:0]    width,
        input logic [W_SIZE_DEF-1:0]    height,
        input logic [W_CHANNEL_DEF-1:0] ch_in,
        input logic [W_CHANNEL_DEF-1:0] ch_out
    );
        return {ch_out, ch_in, height, width};
    endfunction

endpackage

// File: rtl/cnn_layer_sched_if.sv
// Host/controller-facing signal bundle of the layer sequencer. The master side
// is the host plus tile controller, the slave side is the sequencer itself.
interface cnn_layer_sched_if #(
    parameter int unsigned W_SIZE       = cnn_layer_sched_pkg::W_SIZE_DEF,
    parameter int unsigned W_CHANNEL    = cnn_layer_sched_pkg::W_CHANNEL_DEF,
    parameter int unsigned W_FRAME_SIZE = cnn_layer_sched_pkg::W_FRAME_SIZE_DEF,
    parameter int unsigned W_LAYER      = cnn_layer_sched_pkg::W_LAYER_DEF,
    parameter int unsigned W_TIMEOUT    = cnn_layer_sched_pkg::W_TIMEOUT_DEF
) ();

    logic                            cfg_we;
    logic [W_LAYER-1:0]              cfg_addr;
    logic [2*W_SIZE+2*W_CHANNEL-1:0] cfg_wdata;
    logic [W_LAYER:0]                i_num_layers;
    logic [W_TIMEOUT-1:0]            i_timeout;
    logic                            i_start;
    logic                            i_abort;
    logic                            i_layer_done;

    logic                            o_ctrl_rstn;
    logic [W_SIZE-1:0]               o_q_width;
    logic [W_SIZE-1:0]               o_q_height;
    logic [W_CHANNEL-1:0]            o_q_channel;
    logic [W_CHANNEL-1:0]            o_q_channel_out;
    logic [W_FRAME_SIZE-1:0]         o_q_frame_size;
    logic                            o_q_start;
    logic                            o_busy;
    logic [W_LAYER-1:0]              o_cur_layer;
    logic                            o_done;
    logic [1:0]                      o_err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, i_num_layers, i_timeout,
               i_start, i_abort, i_layer_done,
        input  o_ctrl_rstn, o_q_width, o_q_height, o_q_channel, o_q_channel_out,
               o_q_frame_size, o_q_start, o_busy, o_cur_layer, o_done, o_err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, i_num_layers, i_timeout,
               i_start, i_abort, i_layer_done,
        output o_ctrl_rstn, o_q_width, o_q_height, o_q_channel, o_q_channel_out,
               o_q_frame_size, o_q_start, o_busy, o_cur_layer, o_done, o_err
    );

endinterface

// File: rtl/cnn_layer_desc_rf.sv
// Layer descriptor table: synchronous write, registered read (one cycle).
// Table contents are deliberately not reset.
module cnn_layer_desc_rf #(
    parameter int unsigned N_LAYER = 16,
    parameter int unsigned W_LAYER = 4,
    parameter int unsigned W_DESC  = 36
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic [W_LAYER-1:0] waddr,
    input  logic [W_DESC-1:0]  wdata,
    input  logic [W_LAYER-1:0] raddr,
    output logic [W_DESC-1:0]  rdata
);

    logic [W_DESC-1:0] mem [N_LAYER];
    logic [W_DESC-1:0] rdata_q;

    // Host writes into the table
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cnn_layer_sched.sv
// Multi-layer sequencer: walks the descriptor table, configures the tile
// controller per layer, pulses its start and waits for its sticky layer-done.
module cnn_layer_sched
    import cnn_layer_sched_pkg::*;
#(
    parameter int unsigned W_SIZE       = W_SIZE_DEF,
    parameter int unsigned W_CHANNEL    = W_CHANNEL_DEF,
    parameter int unsigned W_FRAME_SIZE = W_FRAME_SIZE_DEF,
    parameter int unsigned N_LAYER      = N_LAYER_DEF,
    parameter int unsigned W_LAYER      = W_LAYER_DEF,
    parameter int unsigned W_TIMEOUT    = W_TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rstn,
    cnn_layer_sched_if.slave bus
);

    localparam int unsigned W_DESC = 2 * W_SIZE + 2 * W_CHANNEL;
    localparam int unsigned W_PROD = 2 * W_SIZE + W_CHANNEL;

    sched_state_e            state_q, state_d;
    sched_err_e              err_q, err_d;
    logic [W_LAYER-1:0]      idx_q, idx_d;
    logic [W_LAYER:0]        num_q;
    logic [W_TIMEOUT-1:0]    wdog_q;
    logic                    rst_cnt_q;
    logic                    ctrl_rstn_q;
    logic [W_SIZE-1:0]       width_q, height_q;
    logic [W_CHANNEL-1:0]    ch_in_q, ch_out_q;
    logic [W_FRAME_SIZE-1:0] frame_q;

    logic [W_DESC-1:0]       rd_desc;
    logic [W_PROD-1:0]       product;
    logic [W_TIMEOUT:0]      wdog_next;
    logic                    desc_bad;
    logic                    last_layer;
    logic                    wdog_hit;

    cnn_layer_desc_rf #(
        .N_LAYER (N_LAYER),
        .W_LAYER (W_LAYER),
        .W_DESC  (W_DESC)
    ) u_desc_rf (
        .clk   (clk),
        .rstn  (rstn),
        .we    (bus.cfg_we & ~bus.o_busy),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_wdata),
        .raddr (idx_d),
        .rdata (rd_desc)
    );

    // Frame size, descriptor sanity, last-layer and watchdog decode
    always_comb begin
        product    = W_PROD'(width_q) * W_PROD'(height_q) * W_PROD'(ch_in_q);
        desc_bad   = (width_q == '0) || (height_q == '0) || (ch_in_q == '0) ||
                     (ch_out_q == '0) || (|product[W_PROD-1:W_FRAME_SIZE]);
        // Also stop at the end of the table if more layers were requested
        last_layer = (({1'b0, idx_q} + 1'b1) >= num_q) ||
                     (idx_q == W_LAYER'(N_LAYER - 1));
        wdog_next  = {1'b0, wdog_q} + 1'b1;
        wdog_hit   = (bus.i_timeout != '0) && (wdog_next == {1'b0, bus.i_timeout});
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; abort overrides every transition outside idle
    always_comb begin
        state_d = state_q;
        if (state_q != StIdle && bus.i_abort) begin
            state_d = StDone;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.i_start) begin
                        state_d = (bus.i_num_layers == '0) ? StDone : StLoad;
                    end
                end
                StLoad:  state_d = StCalc;
                StCalc:  state_d = desc_bad ? StDone : StRst;
                StRst:   state_d = rst_cnt_q ? StStart : StRst;
                StStart: state_d = StRun;
                StRun: begin
                    // Layer-done wins over a same-cycle watchdog expiry
                    if (bus.i_layer_done) begin
                        state_d = last_layer ? StDone : StLoad;
                    end else if (wdog_hit) begin
                        state_d = StDone;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs decoded from the current state
    always_comb begin
        bus.o_busy    = (state_q == StLoad) || (state_q == StCalc) || (state_q == StRst) ||
                        (state_q == StStart) || (state_q == StRun);
        bus.o_done    = (state_q == StDone);
        bus.o_q_start = (state_q == StStart);
    end

    // Layer index and sticky error next values
    always_comb begin
        idx_d = idx_q;
        if (state_q == StIdle && state_d == StLoad) begin
            idx_d = '0;
        end else if (state_q == StRun && state_d == StLoad) begin
            idx_d = idx_q + 1'b1;
        end

        err_d = err_q;
        if (state_q == StIdle) begin
            if (bus.i_start) begin
                err_d = ErrNone;
            end
        end else if (bus.i_abort) begin
            err_d = ErrAbort;
        end else if (state_q == StCalc && desc_bad) begin
            err_d = ErrDesc;
        end else if (state_q == StRun && !bus.i_layer_done && wdog_hit) begin
            err_d = ErrTimeout;
        end
    end

    // Datapath: config registers, counters and controller reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q       <= '0;
            err_q       <= ErrNone;
            num_q       <= '0;
            wdog_q      <= '0;
            rst_cnt_q   <= 1'b0;
            ctrl_rstn_q <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            ch_in_q     <= '0;
            ch_out_q    <= '0;
            frame_q     <= '0;
        end else begin
            idx_q       <= idx_d;
            err_q       <= err_d;
            rst_cnt_q   <= (state_q == StRst) ? ~rst_cnt_q : 1'b0;
            wdog_q      <= (state_q == StRun) ? wdog_q + 1'b1 : '0;
            // Controller is out of reset only while starting and running a layer
            ctrl_rstn_q <= (state_d == StStart) || (state_d == StRun);
            if (state_q == StIdle && bus.i_start) begin
                num_q <= bus.i_num_layers;
            end
            if (state_q == StLoad) begin
                width_q  <= rd_desc[W_SIZE-1:0];
                height_q <= rd_desc[2*W_SIZE-1:W_SIZE];
                ch_in_q  <= rd_desc[2*W_SIZE+W_CHANNEL-1:2*W_SIZE];
                ch_out_q <= rd_desc[W_DESC-1:2*W_SIZE+W_CHANNEL];
            end
            if (state_q == StCalc) begin
                frame_q <= product[W_FRAME_SIZE-1:0];
            end
        end
    end

    assign bus.o_ctrl_rstn     = ctrl_rstn_q;
    assign bus.o_q_width       = width_q;
    assign bus.o_q_height      = height_q;
    assign bus.o_q_channel     = ch_in_q;
    assign bus.o_q_channel_out = ch_out_q;
    assign bus.o_q_frame_size  = frame_q;
    assign bus.o_cur_layer     = idx_q;
    assign bus.o_err           = err_q;

endmodule
